// File: rtl/sram_like_req_buf.sv
// rtl/sram_like_req_buf.sv - SRAM-like bus adapter: in-order transaction tracker plus registered read-response FIFO
module sram_like_req_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic                   cpu_req_wr,
  input  logic [DATA_W/8-1:0]    cpu_req_wstrb,
  input  logic [ADDR_W-1:0]      cpu_req_addr,
  input  logic [DATA_W-1:0]      cpu_req_wdata,
  output logic                   cpu_resp_valid,
  input  logic                   cpu_resp_ready,
  output logic [DATA_W-1:0]      cpu_resp_rdata,
  input  logic                   cancel,
  output logic                   req,
  output logic                   wr,
  output logic [DATA_W/8-1:0]    wstrb,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      wdata,
  input  logic                   addr_ok,
  input  logic                   data_ok,
  input  logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0]  trk_wr_q, trk_wr_d;
  logic [DEPTH-1:0]  trk_disc_q, trk_disc_d;
  logic [PW-1:0]     trk_head_q, trk_head_d;
  logic [PW-1:0]     trk_tail_q, trk_tail_d;
  logic [CW-1:0]     trk_cnt_q, trk_cnt_d;
  logic [DATA_W-1:0] rsp_mem_q [DEPTH];
  logic [DATA_W-1:0] rsp_mem_d [DEPTH];
  logic [PW-1:0]     rsp_head_q, rsp_head_d;
  logic [PW-1:0]     rsp_tail_q, rsp_tail_d;
  logic [CW-1:0]     rsp_cnt_q, rsp_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic trk_push, trk_pop, rsp_push, rsp_pop;

  always_comb begin
    wr    = cpu_req_wr;
    wstrb = cpu_req_wstrb;
    addr  = cpu_req_addr;
    wdata = cpu_req_wdata;

    // Credit check uses the registered count only, so a same-cycle data_ok never frees a slot early.
    outstanding    = trk_cnt_q + rsp_cnt_q;
    req            = !reset && cpu_req_valid && !cancel && (outstanding < FULL_CNT);
    cpu_req_ready  = req && addr_ok;
    cpu_resp_valid = (rsp_cnt_q != '0);
    cpu_resp_rdata = rsp_mem_q[rsp_head_q];
    proto_err      = proto_err_q;

    trk_push = cpu_req_ready;
    trk_pop  = data_ok && (trk_cnt_q != '0);
    rsp_push = trk_pop && !trk_wr_q[trk_head_q] && !trk_disc_q[trk_head_q] && !cancel;
    rsp_pop  = cpu_resp_valid && cpu_resp_ready;

    trk_wr_d    = trk_wr_q;
    trk_disc_d  = trk_disc_q;
    trk_head_d  = trk_head_q;
    trk_tail_d  = trk_tail_q;
    trk_cnt_d   = trk_cnt_q + CW'(trk_push) - CW'(trk_pop);
    rsp_mem_d   = rsp_mem_q;
    rsp_head_d  = rsp_head_q;
    rsp_tail_d  = rsp_tail_q;
    rsp_cnt_d   = rsp_cnt_q + CW'(rsp_push) - CW'(rsp_pop);
    proto_err_d = proto_err_q || (data_ok && (trk_cnt_q == '0));

    if (cancel) begin
      trk_disc_d = '1;
    end
    if (trk_push) begin
      trk_wr_d[trk_tail_q]   = cpu_req_wr;
      trk_disc_d[trk_tail_q] = 1'b0;
      trk_tail_d             = trk_tail_q + 1'b1;
    end
    if (trk_pop) begin
      trk_head_d = trk_head_q + 1'b1;
    end

    if (rsp_push) begin
      rsp_mem_d[rsp_tail_q] = rdata;
      rsp_tail_d            = rsp_tail_q + 1'b1;
    end
    if (rsp_pop) begin
      rsp_head_d = rsp_head_q + 1'b1;
    end
    // A flush empties the response FIFO; nothing is pushed in that cycle, so tail is already final.
    if (cancel) begin
      rsp_head_d = rsp_tail_q;
      rsp_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trk_wr_q    <= '0;
      trk_disc_q  <= '0;
      trk_head_q  <= '0;
      trk_tail_q  <= '0;
      trk_cnt_q   <= '0;
      rsp_head_q  <= '0;
      rsp_tail_q  <= '0;
      rsp_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      trk_wr_q    <= trk_wr_d;
      trk_disc_q  <= trk_disc_d;
      trk_head_q  <= trk_head_d;
      trk_tail_q  <= trk_tail_d;
      trk_cnt_q   <= trk_cnt_d;
      rsp_head_q  <= rsp_head_d;
      rsp_tail_q  <= rsp_tail_d;
      rsp_cnt_q   <= rsp_cnt_d;
      proto_err_q <= proto_err_d;
    end
    rsp_mem_q <= rsp_mem_d;
  end

endmodule

// File: tb/tb_sram_like_req_buf.sv
// tb/tb_sram_like_req_buf.sv - queue-model checked bench for sram_like_req_buf
module tb_sram_like_req_buf;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   cpu_req_valid, cpu_req_ready, cpu_req_wr;
  logic [DATA_W/8-1:0]    cpu_req_wstrb;
  logic [ADDR_W-1:0]      cpu_req_addr;
  logic [DATA_W-1:0]      cpu_req_wdata;
  logic                   cpu_resp_valid, cpu_resp_ready;
  logic [DATA_W-1:0]      cpu_resp_rdata;
  logic                   cancel;
  logic                   req, wr;
  logic [DATA_W/8-1:0]    wstrb;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      wdata;
  logic                   addr_ok, data_ok;
  logic [DATA_W-1:0]      rdata;
  logic [$clog2(DEPTH):0] outstanding;
  logic                   proto_err;

  sram_like_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_wr(cpu_req_wr),
    .cpu_req_wstrb(cpu_req_wstrb), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready), .cpu_resp_rdata(cpu_resp_rdata),
    .cancel(cancel), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_wr; logic disc; } trk_t;
  trk_t              m_trk [$];
  logic [DATA_W-1:0] m_rsp [$];
  logic              m_perr = 1'b0;
  logic              m_live = 1'b0;
  logic              last_hs = 1'b0, last_cancel = 1'b0, last_reset = 1'b0;
  int                errors = 0;
  int                checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: transactions are queue entries; outputs follow from queue sizes and heads.
  always @(negedge clk) begin : model
    int   occ;
    logic e_req, e_push;
    trk_t e;
    occ   = m_trk.size() + m_rsp.size();
    e_req = !reset && cpu_req_valid && !cancel && (occ < DEPTH);
    if (m_live) begin
      chk("req", req, e_req);
      chk("cpu_req_ready", cpu_req_ready, e_req && addr_ok);
      chk("wr", wr, cpu_req_wr);
      chk("wstrb", wstrb, cpu_req_wstrb);
      chk("addr", addr, cpu_req_addr);
      chk("wdata", wdata, cpu_req_wdata);
      chk("cpu_resp_valid", cpu_resp_valid, m_rsp.size() != 0);
      if (m_rsp.size() != 0) chk("cpu_resp_rdata", cpu_resp_rdata, m_rsp[0]);
      chk("outstanding", outstanding, occ);
      chk("proto_err", proto_err, m_perr);
    end
    last_hs     = e_req && addr_ok;
    last_cancel = cancel;
    last_reset  = reset;
    if (reset) begin
      m_trk.delete();
      m_rsp.delete();
      m_perr = 1'b0;
      m_live = 1'b1;
    end else begin
      e_push = 1'b0;
      if (data_ok) begin
        if (m_trk.size() == 0) m_perr = 1'b1;
        else begin
          e = m_trk.pop_front();
          e_push = !e.is_wr && !e.disc && !cancel;
        end
      end
      if (m_rsp.size() != 0 && cpu_resp_ready) void'(m_rsp.pop_front());
      if (e_push) m_rsp.push_back(rdata);
      if (cancel) begin
        m_rsp.delete();
        foreach (m_trk[k]) m_trk[k].disc = 1'b1;
      end
      if (e_req && addr_ok) m_trk.push_back('{is_wr: cpu_req_wr, disc: 1'b0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic idle();
    reset = 0; cpu_req_valid = 0; cpu_req_wr = 0; cpu_req_wstrb = '0; cpu_req_addr = '0;
    cpu_req_wdata = '0; cpu_resp_ready = 0; cancel = 0; addr_ok = 0; data_ok = 0; rdata = '0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    idle(); cpu_req_valid = 1; cpu_req_addr = a; addr_ok = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (3) tick();

    // single read
    rd(32'h1c000000); look();
    chk("s1_out0", outstanding, 0); chk("s1_ready", cpu_req_ready, 1);
    tick(); idle(); look(); chk("s1_out1", outstanding, 1);
    tick(); idle(); data_ok = 1; rdata = 32'hDEADBEEF; look();
    chk("s1_out2", outstanding, 1); chk("s1_nv", cpu_resp_valid, 0);
    tick(); idle(); cpu_resp_ready = 1; look();
    chk("s1_valid", cpu_resp_valid, 1); chk("s1_data", cpu_resp_rdata, 32'hDEADBEEF);
    chk("s1_out3", outstanding, 1);
    tick(); idle(); look(); chk("s1_out4", outstanding, 0); chk("s1_nv2", cpu_resp_valid, 0);

    // back-pressure at DEPTH
    tick(); rd(32'h1c000010); look(); chk("s2_r1", cpu_req_ready, 1);
    tick(); rd(32'h1c000014); look(); chk("s2_r2", cpu_req_ready, 1);
    tick(); rd(32'h1c000018); data_ok = 1; rdata = 32'h11; look();
    chk("s2_blk", req, 0); chk("s2_out", outstanding, 2);
    tick(); rd(32'h1c000018); data_ok = 1; rdata = 32'h22; look(); chk("s2_blk2", req, 0);
    tick(); rd(32'h1c000018); cpu_resp_ready = 1; look();
    chk("s2_d11", cpu_resp_rdata, 32'h11); chk("s2_blk3", req, 0); chk("s2_out2", outstanding, 2);
    tick(); rd(32'h1c000018); cpu_resp_ready = 1; look();
    chk("s2_d22", cpu_resp_rdata, 32'h22); chk("s2_issue", cpu_req_ready, 1);
    tick(); idle(); cpu_resp_ready = 1; look(); chk("s2_out3", outstanding, 1);
    tick(); idle(); cpu_resp_ready = 1; data_ok = 1; rdata = 32'h55; look();
    tick(); idle(); cpu_resp_ready = 1; look(); chk("s2_d55", cpu_resp_rdata, 32'h55);
    tick(); idle(); look(); chk("s2_out4", outstanding, 0);

    // write then read: write ack never surfaces
    tick(); idle(); cpu_req_valid = 1; cpu_req_wr = 1; cpu_req_wstrb = 4'hF;
    cpu_req_addr = 32'h1c000004; cpu_req_wdata = 32'hA5A5A5A5; addr_ok = 1; look();
    chk("s3_wr", wr, 1); chk("s3_wdata", wdata, 32'hA5A5A5A5); chk("s3_wstrb", wstrb, 4'hF);
    tick(); rd(32'h1c000008); look();
    tick(); idle(); data_ok = 1; rdata = 32'h00000BAD; look();
    tick(); idle(); data_ok = 1; rdata = 32'h77777777; look(); chk("s3_nowr", cpu_resp_valid, 0);
    tick(); idle(); cpu_resp_ready = 1; look();
    chk("s3_v", cpu_resp_valid, 1); chk("s3_d", cpu_resp_rdata, 32'h77777777);
    tick(); idle(); look(); chk("s3_out", outstanding, 0);

    // cancel with two reads in flight
    tick(); rd(32'h1c000020); look();
    tick(); rd(32'h1c000024); look();
    tick(); idle(); cancel = 1; look(); chk("s4_out", outstanding, 2);
    tick(); idle(); data_ok = 1; rdata = 32'h33; look(); chk("s4_out1", outstanding, 2);
    tick(); idle(); data_ok = 1; rdata = 32'h44; look();
    chk("s4_out2", outstanding, 1); chk("s4_nv", cpu_resp_valid, 0);
    tick(); idle(); look(); chk("s4_out3", outstanding, 0); chk("s4_nv2", cpu_resp_valid, 0);
    tick(); rd(32'h1c000028); look();
    tick(); idle(); data_ok = 1; rdata = 32'h66; look();
    tick(); idle(); cpu_resp_ready = 1; look(); chk("s4_d66", cpu_resp_rdata, 32'h66);
    tick(); idle(); look();

    // cancel colliding with data_ok and a new request
    tick(); rd(32'h1c000030); look();
    tick(); rd(32'h1c000034); cancel = 1; data_ok = 1; rdata = 32'h99; look();
    chk("s5_req", req, 0); chk("s5_rdy", cpu_req_ready, 0);
    tick(); idle(); look(); chk("s5_out", outstanding, 0); chk("s5_nv", cpu_resp_valid, 0);

    // push and pop of the response FIFO in one cycle
    tick(); rd(32'h1c000040); look();
    tick(); rd(32'h1c000044); look();
    tick(); idle(); data_ok = 1; rdata = 32'hAA; look();
    tick(); idle(); data_ok = 1; rdata = 32'hBB; cpu_resp_ready = 1; look();
    chk("s5_dAA", cpu_resp_rdata, 32'hAA); chk("s5_out2", outstanding, 2);
    tick(); idle(); cpu_resp_ready = 1; look();
    chk("s5_dBB", cpu_resp_rdata, 32'hBB); chk("s5_out3", outstanding, 1);
    tick(); idle(); look();

    // randomized traffic; requests held until accepted unless flushed
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset  = ($urandom_range(0, 599) == 0);
      cancel = !reset && ($urandom_range(0, 15) == 0);
      if (!(cpu_req_valid && !last_hs && !last_cancel && !last_reset)) begin
        cpu_req_valid = $urandom_range(0, 1);
        cpu_req_wr    = $urandom_range(0, 2) == 0;
        cpu_req_wstrb = 4'($urandom);
        cpu_req_addr  = $urandom;
        cpu_req_wdata = $urandom;
      end
      addr_ok        = $urandom_range(0, 2) != 0;
      cpu_resp_ready = $urandom_range(0, 4) < 3;
      if (m_trk.size() != 0) data_ok = $urandom_range(0, 1);
      else data_ok = ($urandom_range(0, 149) == 0);
      rdata = $urandom;
    end

    // sticky protocol error, then reset clears everything
    tick(); idle(); reset = 1; look();
    tick(); idle(); data_ok = 1; look();
    tick(); idle(); look(); chk("s6_perr", proto_err, 1); chk("s6_out", outstanding, 0);
    tick(); rd(32'h1c000050); look();
    tick(); idle(); look(); chk("s6_perr2", proto_err, 1); chk("s6_out1", outstanding, 1);
    tick(); idle(); reset = 1; cpu_req_valid = 1; addr_ok = 1; look();
    chk("s6_rreq", req, 0); chk("s6_rrdy", cpu_req_ready, 0);
    tick(); idle(); look();
    chk("s6_perr0", proto_err, 0); chk("s6_out0", outstanding, 0); chk("s6_nv", cpu_resp_valid, 0);
    tick(); idle(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
